// File: rtl/joypad_serializer.sv
// Multi-port NES/SNES joypad serializer: latches host button vectors on strobe
// and shifts one bit per falling edge of each port's read clock.
`timescale 1ns/1ps

module joypad_port #(
   parameter int C_bits = 8,
   parameter int C_fill = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              strobe,
   input  logic              rclk,
   input  logic [C_bits-1:0] load,
   output logic              data,
   output logic              overread
);
   localparam int CW = $clog2(C_bits + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(C_bits);
   localparam logic FILL = (C_fill != 0);

   logic [C_bits-1:0] shreg;
   logic [CW-1:0]     cnt;
   logic              clk_prev;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         shreg    <= {C_bits{FILL}};
         cnt      <= '0;
         overread <= 1'b0;
         clk_prev <= 1'b0;
      end else begin
         clk_prev <= rclk;
         // load has priority so an edge coinciding with strobe is dropped
         if (strobe) begin
            shreg    <= load;
            cnt      <= '0;
            overread <= 1'b0;
         end else if (clk_prev && !rclk) begin
            shreg <= {FILL, shreg[C_bits-1:1]};
            if (cnt == CNT_MAX) overread <= 1'b1;
            else                cnt      <= cnt + 1'b1;
         end
      end
   end

   assign data = shreg[0];
endmodule

module joypad_serializer #(
   parameter int C_ports       = 2,
   parameter int C_bits        = 8,
   parameter int C_fill        = 1,
   parameter int C_clk_hz      = 21428571,
   parameter int C_autofire_hz = 10
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [C_ports*C_bits-1:0] i_btn,
   input  logic [C_bits-1:0]         i_turbo_mask,
   input  logic                      i_strobe,
   input  logic [C_ports-1:0]        i_clock,
   output logic [C_ports-1:0]        o_data,
   output logic [C_ports-1:0]        o_overread
);
   localparam bit AF_EN = (C_autofire_hz > 0);
   localparam int H     = AF_EN ? C_clk_hz / (2 * C_autofire_hz) : 1;
   localparam int AFW   = (H > 1) ? $clog2(H) : 1;
   localparam logic [AFW-1:0] AF_LAST = AFW'(H - 1);

   logic [C_ports-1:0][C_bits-1:0] r_btn;
   logic [AFW-1:0]                 r_af;
   logic                           r_phase;
   logic [C_bits-1:0]              keep;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_btn   <= '0;
         r_af    <= '0;
         r_phase <= 1'b1;
      end else begin
         r_btn <= i_btn;
         if (AF_EN) begin
            if (r_af == AF_LAST) begin
               r_af    <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_af <= r_af + 1'b1;
            end
         end
      end
   end

   // turbo buttons read released during the low autofire phase
   assign keep = ~(i_turbo_mask & ~{C_bits{r_phase}});

   for (genvar p = 0; p < C_ports; p++) begin : g_port
      joypad_port #(
         .C_bits (C_bits),
         .C_fill (C_fill)
      ) u_port (
         .clk      (clk),
         .resetn   (resetn),
         .strobe   (i_strobe),
         .rclk     (i_clock[p]),
         .load     (r_btn[p] & keep),
         .data     (o_data[p]),
         .overread (o_overread[p])
      );
   end
endmodule

// File: tb/tb_joypad_serializer.sv
// Scoreboard bench for joypad_serializer: an 8-bit/fill-1/autofire instance
// and a 16-bit/fill-0/no-autofire instance driven from directed sequences.
`timescale 1ns/1ps

module tb_joypad_serializer;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [15:0] a_btn;
   logic [7:0]  a_mask;
   logic        a_strobe;
   logic [1:0]  a_clk, a_data, a_ovr;

   logic [31:0] b_btn;
   logic [15:0] b_mask;
   logic        b_strobe;
   logic [1:0]  b_clk, b_data, b_ovr;

   joypad_serializer #(
      .C_ports(2), .C_bits(8), .C_fill(1), .C_clk_hz(1000), .C_autofire_hz(100)
   ) dut8 (
      .clk(clk), .resetn(resetn), .i_btn(a_btn), .i_turbo_mask(a_mask),
      .i_strobe(a_strobe), .i_clock(a_clk), .o_data(a_data), .o_overread(a_ovr)
   );

   joypad_serializer #(
      .C_ports(2), .C_bits(16), .C_fill(0), .C_clk_hz(1000), .C_autofire_hz(0)
   ) dut16 (
      .clk(clk), .resetn(resetn), .i_btn(b_btn), .i_turbo_mask(b_mask),
      .i_strobe(b_strobe), .i_clock(b_clk), .o_data(b_data), .o_overread(b_ovr)
   );

   typedef struct {
      int    due;
      int    dut;
      int    port;
      logic  d;
      logic  o;
      string name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compares every expectation that falls due in this cycle
   always @(negedge clk) begin
      logic ad, ao;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            ad = (sb[i].dut == 0) ? a_data[sb[i].port] : b_data[sb[i].port];
            ao = (sb[i].dut == 0) ? a_ovr[sb[i].port]  : b_ovr[sb[i].port];
            checks++;
            if (sb[i].due < cyc) begin
               errors++;
               $display("FAIL %s: expectation for cycle %0d expired at cycle %0d",
                        sb[i].name, sb[i].due, cyc);
            end else if (ad !== sb[i].d || ao !== sb[i].o) begin
               errors++;
               $display("FAIL %s (cycle %0d): data=%b overread=%b, expected data=%b overread=%b",
                        sb[i].name, cyc, ad, ao, sb[i].d, sb[i].o);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_out(int dut, int port, logic d, logic o, string name);
      exp_t e;
      e.due = cyc; e.dut = dut; e.port = port; e.d = d; e.o = o; e.name = name;
      sb.push_back(e);
   endtask

   task automatic edge_a(logic [1:0] m);
      a_clk = m; step();
      a_clk = 2'b00; step();
   endtask

   task automatic edge_b(logic [1:0] m);
      b_clk = m; step();
      b_clk = 2'b00; step();
   endtask

   task automatic strobe_a();
      a_strobe = 1'b1; step();
      a_strobe = 1'b0;
   endtask

   initial begin
      logic [7:0]  v8;
      logic [15:0] v16;
      resetn = 1'b0;
      a_btn = '0; a_mask = '0; a_strobe = 1'b0; a_clk = 2'b11;
      b_btn = '0; b_mask = 16'hFFFF; b_strobe = 1'b0; b_clk = 2'b11;

      // reset state, read clocks held high across release
      step(3);
      exp_out(0, 0, 1'b1, 1'b0, "reset_a0");
      exp_out(0, 1, 1'b1, 1'b0, "reset_a1");
      exp_out(1, 0, 1'b0, 1'b0, "reset_b0");
      resetn = 1'b1;
      step(2);
      exp_out(0, 0, 1'b1, 1'b0, "release_a0");
      exp_out(1, 1, 1'b0, 1'b0, "release_b1");
      a_clk = 2'b00; b_clk = 2'b00;
      step();

      // basic 8-bit read with over-read
      v8 = 8'hA5;
      a_btn = {8'h00, v8};
      step();
      strobe_a();
      exp_out(0, 0, 1'b1, 1'b0, "read_bit0");
      for (int k = 1; k <= 10; k++) begin
         edge_a(2'b01);
         exp_out(0, 0, (k < 8) ? v8[k] : 1'b1, (k >= 9), "read_edge");
      end
      exp_out(0, 1, 1'b0, 1'b0, "read_port1_idle");
      strobe_a();
      exp_out(0, 0, 1'b1, 1'b0, "restrobe_clears");

      // port independence, then a simultaneous edge on both ports
      a_btn = {8'h80, 8'h01};
      step();
      strobe_a();
      exp_out(0, 1, 1'b0, 1'b0, "indep_p1_bit0");
      for (int k = 1; k <= 7; k++) begin
         edge_a(2'b10);
         exp_out(0, 1, (k == 7), 1'b0, "indep_p1");
         exp_out(0, 0, 1'b1, 1'b0, "indep_p0_steady");
      end
      edge_a(2'b11);
      exp_out(0, 1, 1'b1, 1'b0, "both_p1_fill");
      exp_out(0, 0, 1'b0, 1'b0, "both_p0_bit1");

      // strobe and falling edge in the same cycle: load wins
      a_btn = {8'h00, 8'hFE};
      step();
      strobe_a();
      exp_out(0, 0, 1'b0, 1'b0, "coll_pre_bit0");
      edge_a(2'b01);
      exp_out(0, 0, 1'b1, 1'b0, "coll_pre_bit1");
      a_clk = 2'b01; step();
      a_clk = 2'b00; a_strobe = 1'b1; step();
      a_strobe = 1'b0;
      exp_out(0, 0, 1'b0, 1'b0, "coll_load_wins");
      step();
      exp_out(0, 0, 1'b0, 1'b0, "coll_hold");
      edge_a(2'b01);
      exp_out(0, 0, 1'b1, 1'b0, "coll_next_bit1");
      step(3);
      exp_out(0, 0, 1'b1, 1'b0, "idle_hold");

      // 16-bit mode, fill 0, mask ignored with autofire disabled
      v16 = 16'h8001;
      b_btn = {16'h0000, v16};
      step();
      b_strobe = 1'b1; step(); b_strobe = 1'b0;
      exp_out(1, 0, 1'b1, 1'b0, "w16_bit0");
      for (int k = 1; k <= 17; k++) begin
         edge_b(2'b01);
         exp_out(1, 0, (k < 16) ? v16[k] : 1'b0, (k == 17), "w16_edge");
      end

      // reset mid-read, then autofire with strobe held high (H = 5)
      a_btn = 16'h0001; a_mask = 8'h01; a_strobe = 1'b1;
      a_clk = 2'b10; step();
      a_clk = 2'b00; resetn = 1'b0;
      step(2);
      exp_out(0, 0, 1'b1, 1'b0, "midread_reset_p0");
      exp_out(0, 1, 1'b1, 1'b0, "midread_reset_p1");
      resetn = 1'b1;
      step();
      exp_out(0, 0, 1'b0, 1'b0, "af_rbtn_cleared");
      for (int k = 2; k <= 25; k++) begin
         step();
         exp_out(0, 0, (k <= 5) ? 1'b1 : (((k - 6) / 5) % 2 == 1), 1'b0, "autofire");
      end
      a_mask = 8'h00;
      for (int k = 0; k < 10; k++) begin
         step();
         exp_out(0, 0, 1'b1, 1'b0, "autofire_masked_off");
      end
      a_strobe = 1'b0;

      step(2);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never compared", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/joypad_serializer.md
# joypad_serializer

Parametrised controller-port block that presents host-side button vectors to the NES core as serial joypads. Each port latches its buttons while strobe is high and shifts one bit out per falling edge of its read clock. It generalises the single-port 8-bit in-line shifter to N ports, 8-bit (NES) or 16-bit (SNES-style) reports, a configurable over-read fill value, and per-button autofire. It sits between the USB report decoder / GPIO button sources and the NES `joypad_*` pins, in the NES `clock` domain.

## Interface
- `C_ports`, 2: number of independent controller ports.
- `C_bits`, 8: report length per port (8 or 16).
- `C_fill`, 1: bit value shifted in once a port's report is exhausted.
- `C_clk_hz`, 21428571: frequency of `clk` in Hz.
- `C_autofire_hz`, 10: autofire toggle rate; 0 disables autofire.

- `clk`  in  1  system clock (NES `clock`); single clock domain.
- `resetn`  in  1  reset, synchronous, active-low.
- `i_btn`  in  C_ports*C_bits  pressed buttons, active-high; port p occupies bits [p*C_bits +: C_bits]; bit 0 is read first.
- `i_turbo_mask`  in  C_bits  buttons subject to autofire, shared by all ports.
- `i_strobe`  in  1  latch request from NES; level-sensitive.
- `i_clock`  in  C_ports  per-port read clock; shift on falling edge.
- `o_data`  out  C_ports  current serial bit per port, active-high pressed.
- `o_overread`  out  C_ports  sticky flag: port read more than C_bits times since the last strobe.

## Operation
- Input stage: `i_btn` is registered every cycle into `r_btn`. `i_clock` is registered into `r_clk_prev`.
- Autofire: counter `r_af` runs 0..H-1, where H = C_clk_hz/(2*C_autofire_hz). At H-1 it wraps to 0 and `r_phase` toggles. Effective buttons are `r_btn & ~(i_turbo_mask & ~r_phase)`, so a turbo button reads released while `r_phase`=0. With C_autofire_hz=0, `r_phase` stays 1 and the counter stays 0.
- Per port p, each cycle, in priority order:
  - `i_strobe`=1: load `shreg[p]` with the effective buttons for port p; `cnt[p]`←0; `o_overread[p]`←0.
  - Else, if a falling edge (`r_clk_prev[p]`=1, `i_clock[p]`=0): `shreg[p]` ← {C_fill, shreg[p][C_bits-1:1]}. If `cnt[p]`==C_bits, `o_overread[p]`←1; otherwise `cnt[p]`←`cnt[p]`+1. `cnt` saturates at C_bits and is clog2(C_bits+1) bits wide.
  - Else: hold.
- `o_data[p]` = `shreg[p][0]`, driven directly from the register.
- Ports are fully independent. Simultaneous edges on several ports each shift their own port in the same cycle.
- Strobe and a falling edge in the same cycle: the load wins and the edge is discarded.
- Strobe held high: reloads every cycle, so `o_data` tracks button 0 live with a 2-cycle delay.

## Timing
- Reset (`resetn`=0 at a `clk` edge) sets:
  - `shreg` to all C_fill, so `o_data` = {C_ports{C_fill}}
  - `cnt`=0, `o_overread`=0
  - `r_clk_prev`=0, `r_btn`=0
  - `r_af`=0, `r_phase`=1
- Reset asserted mid-read discards any partial report.
- With `r_clk_prev`=0 after reset, a read clock held high through reset release produces no edge.
- `i_btn` change to `o_data`: 2 cycles with strobe high (register, then load).
- Falling edge to `o_data` update: the edge is visible in the cycle when `i_clock` is sampled low, and `o_data` shows the new bit the following cycle.
- `i_clock` low/high phases must each last at least 1 `clk` cycle. `i_strobe`, `i_clock` and `i_btn` are synchronous to `clk`; no synchroniser inside.

## Test plan
- Reset: drive `resetn`=0 for 3 cycles with C_fill=1 -> `o_data`=2'b11, `o_overread`=0; after release, no shift with `i_clock` held high.
- Basic read, C_bits=8: `i_btn[7:0]`=8'hA5, strobe pulse, then 8 falling edges on `i_clock[0]` -> `o_data[0]` sequence 1,0,1,0,0,1,0,1. The 9th and 10th edges give 1,1 and `o_overread[0]`=1. The next strobe clears it.
- Port independence: port0=8'h01, port1=8'h80; edges only on `i_clock[1]` -> port1 yields 0×7 then 1, while `o_data[0]` stays 1.
- Strobe/edge collision: falling edge of `i_clock[0]` in the same cycle `i_strobe` rises -> no shift, and `o_data[0]` equals the new bit 0.
- Autofire with C_clk_hz=1000, C_autofire_hz=100 (H=5): hold `i_btn[0]`=1, `i_turbo_mask`=8'h01, strobe held high -> `o_data[0]` is 1 for 5 cycles, then 0 for 5, repeating. With mask 0 it stays 1.
- 16-bit mode (C_bits=16, C_fill=0): `i_btn`=16'h8001 -> read sequence 1, fourteen 0s, 1, then 0s; `o_overread` sets on the 17th edge.
